// File: rtl/load_pkg.sv
// Shared types for the data-memory load engine: FSM states and load_type codes.
// Latency: n/a (declarations and one pure function only).
// Backpressure: n/a.
package load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LW  = 3'b010;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    // A command is legal when its type is known and the address is
    // naturally aligned for that access size.
    function automatic logic cmd_ok(input logic [2:0] lt, input logic [1:0] off);
        logic ok;
        case (lt)
            LT_LB, LT_LBU: ok = 1'b1;
            LT_LH, LT_LHU: ok = ~off[0];
            LT_LW:         ok = (off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select plus sign/zero extension of a little-endian read word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result follows the inputs.
// Ports: load_type (3b code), addr (byte offset [1:0]), rdata (32b word) -> result (32b).
module load_extend
    import load_pkg::*;
(
    input  logic [2:0]  load_type,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = 32'h0;
        case (load_type)
            LT_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  result = {24'h0, byte_sel};
            LT_LH:   result = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  result = {16'h0, half_sel};
            LT_LW:   result = rdata;
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle load engine: one command -> mem req/ack -> extended load_data + done pulse.
// Latency: start to done 2 cycles minimum (+1 per wait cycle); error pulse 1 cycle after start.
// Backpressure: load_busy high while not IDLE; load_start ignored then; REQ holds until mem_ack.
// Ports: clock/reset_n; command load_start/load_type/load_addr; status load_busy/load_done/
// load_error/load_data; memory mem_req/mem_addr out, mem_ack/mem_rdata in. All outputs registered.
// Optional feature macro LOAD_UNIT_TIMEOUT_EN: abort REQ to ERR after TIMEOUT_CYCLES without ack.
module load_unit
    import load_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load_start,
    input  logic [2:0]  load_type,
    input  logic [31:0] load_addr,
    output logic        load_busy,
    output logic        load_done,
    output logic        load_error,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_t      state, state_nxt;
    logic [2:0]  type_q;
    logic [1:0]  off_q;
    logic [31:0] ext_data;
    logic        timeout_hit;

    load_extend u_extend (
        .load_type (type_q),
        .addr      (off_q),
        .rdata     (mem_rdata),
        .result    (ext_data)
    );

`ifdef LOAD_UNIT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    // Counts REQ cycles that ended without an ack. The abort fires on the
    // cycle that would make the count reach TIMEOUT_CYCLES; an ack in that
    // same cycle takes priority in the next-state logic.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state != REQ) begin
            wait_cnt <= '0;
        end else if (!mem_ack) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == REQ) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    // No counter in this build; the parameter is only consumed here.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = cmd_ok(load_type, load_addr[1:0]) ? REQ : ERR;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = ERR;
                end
            end
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they are registered
    // yet line up exactly with the state they describe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            mem_req    <= 1'b0;
            load_data  <= 32'h0;
            mem_addr   <= 32'h0;
            type_q     <= LT_LB;
            off_q      <= 2'b00;
        end else begin
            state      <= state_nxt;
            load_busy  <= (state_nxt != IDLE);
            load_done  <= (state_nxt == DONE);
            load_error <= (state_nxt == ERR);
            mem_req    <= (state_nxt == REQ);
            if (state == IDLE && state_nxt == REQ) begin
                type_q   <= load_type;
                off_q    <= load_addr[1:0];
                mem_addr <= {load_addr[31:2], 2'b00};
            end
            if (state == REQ && mem_ack) begin
                load_data <= ext_data;
            end
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: expected results queued at issue, checked at done/error.
// Latency: n/a (bench).
// Backpressure: a negedge memory responder acks after a programmable number of wait cycles.
module tb_load_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        load_start;
    logic [2:0]  load_type;
    logic [31:0] load_addr;
    logic        load_busy, load_done, load_error, mem_req;
    logic [31:0] load_data, mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        resp_ack = 1'b0;
    logic        man_ack  = 1'b0;
    logic        resp_en  = 1'b1;
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic [31:0] mem_word  = 32'h0;
    logic [31:0] exp_addr  = 32'h0;

    assign mem_ack = resp_ack | man_ack;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    logic [31:0] last_data = 32'h0;

    always #5 clock = ~clock;

    load_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_start (load_start),
        .load_type  (load_type),
        .load_addr  (load_addr),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_error (load_error),
        .load_data  (load_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic legal(input logic [2:0] t, input logic [1:0] a);
        if (t == 3'b000 || t == 3'b100) return 1'b1;
        if (t == 3'b001 || t == 3'b101) return (a[0] == 1'b0);
        if (t == 3'b010) return (a == 2'b00);
        return 1'b0;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] t, input logic [1:0] a,
                                          input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (t)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Memory responder: ack after ack_delay REQ cycles, check address at ack.
    always @(negedge clock) begin
        if (resp_en && mem_req) begin
            if (wait_cnt >= ack_delay && !resp_ack) begin
                resp_ack  = 1'b1;
                mem_rdata = mem_word;
                chk("mem_addr", mem_addr, exp_addr);
            end else begin
                resp_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            resp_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    // Scoreboard consumer.
    always @(negedge clock) begin
        if (reset_n && (load_done || load_error)) begin
            if (load_done) done_cnt++;
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_kind", {31'h0, load_error}, {31'h0, e.err});
                chk("sb_data", load_data, e.data);
                last_data = e.data;
            end
        end
    end

    // Issue one command; returns the cycle of done/error and whether mem_req was seen.
    task automatic run_cmd(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w,
                           input int dly, input logic hold,
                           output int lat, output logic saw_req);
        exp_t e;
        int   c;
        e.err    = ~legal(t, a[1:0]);
        e.data   = e.err ? last_data : model(t, a[1:0], w);
        sb.push_back(e);
        mem_word  = w;
        ack_delay = dly;
        exp_addr  = {a[31:2], 2'b00};
        saw_req   = 1'b0;
        lat       = -1;
        @(negedge clock);
        load_start = 1'b1;
        load_type  = t;
        load_addr  = a;
        c = 0;
        while (c < 60) begin
            @(negedge clock);
            c++;
            if (hold && c < 3) begin
                load_start = 1'b1;
                load_type  = 3'b010;
                load_addr  = 32'h0000_0100;
            end else begin
                load_start = 1'b0;
            end
            if (mem_req) saw_req = 1'b1;
            if (load_done || load_error) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("cmd_timeout", 32'd1, 32'd0);
        @(negedge clock);
        load_start = 1'b0;
        chk("idle_busy", {31'h0, load_busy}, 32'd0);
    endtask

    task automatic do_cmd(input string tag, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] w, input int dly);
        int   lat;
        logic saw;
        logic ok;
        ok = legal(t, a[1:0]);
        run_cmd(t, a, w, dly, 1'b0, lat, saw);
        chk({tag, "_lat"}, lat, ok ? 2 + dly : 1);
        chk({tag, "_req"}, {31'h0, saw}, {31'h0, ok});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic saw;
        int   d0;

        reset_n    = 1'b0;
        load_start = 1'b0;
        load_type  = 3'b000;
        load_addr  = 32'h0;
        mem_rdata  = 32'h0;
        repeat (3) @(negedge clock);
        chk("rst_busy",  {31'h0, load_busy},  32'd0);
        chk("rst_done",  {31'h0, load_done},  32'd0);
        chk("rst_error", {31'h0, load_error}, 32'd0);
        chk("rst_req",   {31'h0, mem_req},    32'd0);
        chk("rst_data",  load_data, 32'h0);
        chk("rst_addr",  mem_addr,  32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        // LB from the top byte: sign-extended 0x80, done cycle 2, idle cycle 3.
        do_cmd("lb_1003", 3'b000, 32'h0000_1003, 32'h80FF_1234, 0);
        chk("lb_1003_val", load_data, 32'hFFFF_FF80);

        // LHU upper half with three wait cycles.
        do_cmd("lhu_2002", 3'b101, 32'h0000_2002, 32'hBEEF_0001, 3);
        chk("lhu_2002_val", load_data, 32'h0000_BEEF);
        chk("lhu_2002_addr", mem_addr, 32'h0000_2000);

        // Misaligned LW: error, no request, data held.
        do_cmd("lw_3001", 3'b010, 32'h0000_3001, 32'h1111_1111, 0);
        chk("lw_3001_hold", load_data, 32'h0000_BEEF);

        do_cmd("lh_lo",    3'b001, 32'h0000_0010, 32'h1234_8001, 1);
        do_cmd("lh_hi",    3'b001, 32'h0000_0012, 32'h7FFF_0000, 0);
        do_cmd("lbu_b1",   3'b100, 32'h0000_0005, 32'h1234_AB00, 2);
        do_cmd("lb_b2",    3'b000, 32'h0000_0006, 32'h0055_0000, 0);
        do_cmd("lw_al",    3'b010, 32'hCAFE_0008, 32'hDEAD_BEEF, 1);
        chk("lw_al_val", load_data, 32'hDEAD_BEEF);
        do_cmd("ill_type", 3'b011, 32'h0000_0000, 32'h0, 0);
        do_cmd("ill_7",    3'b111, 32'h0000_0004, 32'h0, 0);
        do_cmd("lh_mis",   3'b001, 32'h0000_0001, 32'h0, 0);
        do_cmd("lhu_mis",  3'b101, 32'h0000_0003, 32'h0, 0);
        do_cmd("lw_mis2",  3'b010, 32'h0000_0002, 32'h0, 0);

        // Repeated start while busy is ignored: exactly one done.
        d0 = done_cnt;
        run_cmd(3'b000, 32'h0000_7001, 32'h0000_7F00, 0, 1'b1, lat, saw);
        chk("hold_lat", lat, 2);
        chk("hold_val", load_data, 32'h0000_007F);
        repeat (3) @(negedge clock);
        chk("hold_one_done", done_cnt - d0, 1);
        chk("hold_sb_empty", sb.size(), 0);

        // Stray ack in IDLE does nothing.
        d0 = done_cnt;
        man_ack = 1'b1;
        repeat (2) @(negedge clock);
        man_ack = 1'b0;
        @(negedge clock);
        chk("stray_busy", {31'h0, load_busy}, 32'd0);
        chk("stray_done", done_cnt - d0, 0);
        chk("stray_data", load_data, 32'h0000_007F);

        // Reset during REQ, then a late ack.
        resp_en = 1'b0;
        d0 = done_cnt;
        @(negedge clock);
        load_start = 1'b1;
        load_type  = 3'b010;
        load_addr  = 32'h0000_0080;
        @(negedge clock);
        load_start = 1'b0;
        chk("rreq_req", {31'h0, mem_req}, 32'd1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rreq_busy", {31'h0, load_busy}, 32'd0);
        chk("rreq_mreq", {31'h0, mem_req},   32'd0);
        chk("rreq_addr", mem_addr, 32'h0);
        chk("rreq_data", load_data, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        man_ack   = 1'b1;
        mem_rdata = 32'hDEAD_DEAD;
        @(negedge clock);
        man_ack = 1'b0;
        @(negedge clock);
        chk("rreq_late_busy", {31'h0, load_busy}, 32'd0);
        chk("rreq_late_done", done_cnt - d0, 0);
        chk("rreq_late_data", load_data, 32'h0);
        last_data = 32'h0;
        resp_en = 1'b1;

        do_cmd("post_rst", 3'b100, 32'h0000_0903, 32'hF000_0000, 0);

`ifdef LOAD_UNIT_TIMEOUT_EN
        // No ack: four REQ cycles, then error in the fifth.
        begin
            exp_t e;
            int   c;
            int   req_cycles;
            e.err  = 1'b1;
            e.data = last_data;
            sb.push_back(e);
            resp_en    = 1'b0;
            req_cycles = 0;
            lat        = -1;
            @(negedge clock);
            load_start = 1'b1;
            load_type  = 3'b010;
            load_addr  = 32'h0000_0040;
            for (c = 1; c < 40; c++) begin
                @(negedge clock);
                load_start = 1'b0;
                if (mem_req) req_cycles++;
                if (load_error) begin
                    lat = c;
                    break;
                end
            end
            chk("to_req_cycles", req_cycles, 4);
            chk("to_err_cycle", lat, 5);
            @(negedge clock);
            chk("to_idle", {31'h0, load_busy}, 32'd0);
            resp_en = 1'b1;
        end
`endif

        repeat (2) @(negedge clock);
        chk("final_sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_unit.md
# load_unit

Multi-cycle data-memory read engine for the pipelined CPU's MEM stage: the read-side counterpart of the pipeline/data registers that write values in. It accepts one load command (address and type), performs a request/acknowledge transaction with data memory, and selects and extends the byte, halfword or word. It returns the value with a one-cycle done pulse and holds busy high to stall the pipeline meanwhile.

## Interface
- TIMEOUT_CYCLES, 16, wait cycles in REQ before abort (used only with the timeout feature)
- clock  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_start  in  1  command strobe, sampled only in IDLE
- load_type  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
- load_addr  in  32  byte address, sampled with load_start
- load_busy  out  1  high whenever state is not IDLE
- load_done  out  1  one-cycle pulse, load_data valid
- load_error  out  1  one-cycle pulse: misaligned, illegal type or timeout
- load_data  out  32  extended result; held until next done
- mem_req  out  1  registered read request
- mem_addr  out  32  word-aligned address (load_addr with [1:0]=0)
- mem_ack  in  1  memory acknowledge; mem_rdata valid in the same cycle
- mem_rdata  in  32  little-endian read word

## Operation
- States: IDLE, REQ, DONE, ERR.
- IDLE, load_start=1 with legal, aligned command: latch type and addr[1:0], drive mem_addr, go to REQ.
- IDLE, load_start=1 with illegal type or misalignment (LH/LHU addr[0]=1; LW addr[1:0]!=0): go to ERR. No memory request is issued.
- REQ: mem_req=1, mem_addr stable. On mem_ack=1, capture extended mem_rdata into load_data and go to DONE.
- DONE: load_done=1, mem_req=0; go to IDLE next cycle.
- ERR: load_error=1; load_data unchanged; go to IDLE next cycle.
- Extraction: byte lane = addr[1:0]; halfword = addr[1] (0 → [15:0], 1 → [31:16]). LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- load_start outside IDLE is ignored. mem_ack outside REQ is ignored.
- Reset values: state IDLE; load_busy, load_done, load_error, mem_req all 0; load_data, mem_addr 32'h0.
- Reset mid-transaction returns to IDLE immediately with no done or error pulse. A later mem_ack is ignored.

## Timing
- Cycle 0: load_start sampled. Cycle 1: mem_req=1, load_busy=1.
- mem_ack seen at end of cycle k (k ≥ 1): load_done=1 in cycle k+1, then IDLE and load_busy=0 in cycle k+2.
- Minimum latency: start to done is 2 cycles; back-to-back commands every 3 cycles.
- Error path: load_error=1 in cycle 1, IDLE in cycle 2.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- LOAD_UNIT_TIMEOUT_EN defined: a wait counter clears on REQ entry and increments each REQ cycle without mem_ack.
  - At TIMEOUT_CYCLES the unit drops mem_req and goes to ERR, pulsing load_error.
  - If mem_ack arrives in the same cycle the count reaches TIMEOUT_CYCLES, the ack wins.
- LOAD_UNIT_TIMEOUT_EN not defined: no counter is built. REQ waits for mem_ack indefinitely and TIMEOUT_CYCLES is unused.

## Structure
- Package load_pkg: state enum (IDLE, REQ, DONE, ERR) and load_type localparams (LT_LB, LT_LH, LT_LW, LT_LBU, LT_LHU).
- Sub-module load_extend: combinational lane select and sign/zero extension.
  - Inputs: load_type, addr[1:0], rdata. Output: the 32-bit result.
  - Reused by the forwarding path.

## Test plan
- LB at addr 0x1003, mem_rdata 0x80FF_1234, ack in cycle 1 → load_data 0xFFFF_FF80, done in cycle 2, busy low in cycle 3.
- LHU at addr 0x2002, mem_rdata 0xBEEF_0001, ack after 3 wait cycles → mem_addr 0x2000, load_data 0x0000_BEEF.
- LW at addr 0x3001 → load_error pulse in cycle 1, mem_req never asserted, load_data unchanged.
- reset_n low during REQ, then mem_ack → outputs zero, no done pulse, state IDLE.
- load_start asserted again while busy → ignored; only one done, matching the first command.
- With LOAD_UNIT_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → mem_req drops after 4 REQ cycles and load_error pulses.
